// File: rtl/wasm_fetch_decode.sv
// wasm_fetch_decode: fetches WASM code bytes one at a time from the loader's
// code memory, decodes opcode plus optional LEB128 immediate, and hands one
// decoded instruction per valid/ready handshake to the execute stage.
// Optional build macro: WASM_ILLEGAL_TRAP_EN (trap on unsupported opcodes).
module wasm_fetch_decode #(
    parameter int ADDR_W        = 32,
    parameter int MAX_LEB_BYTES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rom_mapped,
    input  logic [ADDR_W-1:0] first_instruction,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    input  logic [7:0]        mem_data_out,
    input  logic              mem_ready,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [31:0]       instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [2:0]        instr_len,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              trap,
    output logic              busy
);

    localparam int IDX_W = (MAX_LEB_BYTES > 1) ? $clog2(MAX_LEB_BYTES) : 1;

    // Opcodes followed by an unsigned LEB128 immediate (br, br_if, call, local/global ops).
    localparam int N_UIMM = 8;
    localparam logic [7:0] UIMM_OPS [N_UIMM] = '{
        8'h0C, 8'h0D, 8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24
    };
    // i32.const carries a signed LEB128 immediate.
    localparam logic [7:0] OP_I32_CONST = 8'h41;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_IMM,
        S_EMIT,
        S_TRAP
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_mem_read_en;
    logic               r_instr_valid;
    logic               r_trap;
    logic [7:0]         r_opcode;
    logic [31:0]        r_imm;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic [2:0]         r_len;
    logic [31:0]        r_acc;      // partial immediate being assembled
    logic [IDX_W-1:0]   r_leb_idx;  // index of the next immediate byte
    logic               r_signed;   // current immediate is signed LEB

    logic [N_UIMM-1:0]  w_uimm_hit;
    logic               w_needs_uimm;
    logic               w_needs_simm;
    logic [5:0]         w_shift;
    logic [5:0]         w_ext_shift;
    logic [31:0]        w_payload;
    logic [31:0]        w_acc_next;
    logic [31:0]        w_sign_mask;
    logic               w_sext;
    logic [31:0]        w_imm_final;
    logic               w_leb_last;
    logic               w_redirect;
    logic [ADDR_W-1:0]  w_pc_inc;

    // Opcode classification, one comparator per immediate-bearing opcode.
    generate
        for (genvar gi = 0; gi < N_UIMM; gi++) begin : g_uimm
            assign w_uimm_hit[gi] = (mem_data_out == UIMM_OPS[gi]);
        end
    endgenerate

    assign w_needs_uimm = |w_uimm_hit;
    assign w_needs_simm = (mem_data_out == OP_I32_CONST);

`ifdef WASM_ILLEGAL_TRAP_EN
    localparam int N_SUP = 19;
    localparam logic [7:0] SUP_OPS [N_SUP] = '{
        8'h00, 8'h01, 8'h0B, 8'h0C, 8'h0D, 8'h0F, 8'h10, 8'h1A, 8'h20, 8'h21,
        8'h22, 8'h23, 8'h24, 8'h41, 8'h45, 8'h46, 8'h6A, 8'h6B, 8'h6C
    };
    logic [N_SUP-1:0] w_sup_hit;
    logic             w_supported;

    // Supported-opcode lookup used to trap on anything outside the set.
    generate
        for (genvar gi = 0; gi < N_SUP; gi++) begin : g_sup
            assign w_sup_hit[gi] = (mem_data_out == SUP_OPS[gi]);
        end
    endgenerate

    assign w_supported = |w_sup_hit;
`endif

    // LEB128 accumulation: bits shifted past bit 31 (upper payload of the
    // 5th byte) fall off the 32-bit result instead of trapping.
    assign w_shift     = 6'(r_leb_idx) * 6'd7;
    assign w_ext_shift = w_shift + 6'd7;
    assign w_payload   = {25'd0, mem_data_out[6:0]} << w_shift;
    assign w_acc_next  = r_acc | w_payload;
    assign w_sign_mask = 32'hFFFF_FFFF << w_ext_shift;
    // Only a terminating byte that leaves the value short of 32 bits needs extension.
    assign w_sext      = r_signed && (r_leb_idx < IDX_W'(4)) && mem_data_out[6];
    assign w_imm_final = w_sext ? (w_acc_next | w_sign_mask) : w_acc_next;
    assign w_leb_last  = (r_leb_idx == IDX_W'(MAX_LEB_BYTES - 1));

    assign w_redirect  = redirect_valid &&
                         ((r_state == S_FETCH_OP) || (r_state == S_FETCH_IMM) ||
                          (r_state == S_EMIT));
    assign w_pc_inc    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Main fetch/decode FSM with registered memory request and instruction outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_mem_read_en <= 1'b0;
            r_instr_valid <= 1'b0;
            r_trap        <= 1'b0;
            r_opcode      <= '0;
            r_imm         <= '0;
            r_instr_pc    <= '0;
            r_len         <= '0;
            r_acc         <= '0;
            r_leb_idx     <= '0;
            r_signed      <= 1'b0;
        end else if (w_redirect) begin
            // Redirect beats everything: any in-flight byte or pending
            // instruction is dropped and fetch restarts at the target.
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
            r_mem_read_en <= 1'b0;
            r_acc         <= '0;
            r_leb_idx     <= '0;
            r_state       <= S_FETCH_OP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rom_mapped) begin
                        r_pc          <= first_instruction;
                        r_mem_read_en <= 1'b1;
                        r_state       <= S_FETCH_OP;
                    end
                end

                S_FETCH_OP: begin
                    if (!r_mem_read_en) begin
                        // Idle gap after the previous byte is over; request again.
                        r_mem_read_en <= 1'b1;
                    end else if (mem_ready) begin
                        r_mem_read_en <= 1'b0;
                        r_pc          <= w_pc_inc;
                        r_opcode      <= mem_data_out;
                        r_instr_pc    <= r_pc;
                        r_len         <= 3'd1;
                        r_acc         <= '0;
                        r_leb_idx     <= '0;
                        r_signed      <= w_needs_simm;
`ifdef WASM_ILLEGAL_TRAP_EN
                        if (!w_supported) begin
                            r_trap  <= 1'b1;
                            r_state <= S_TRAP;
                        end else
`endif
                        if (w_needs_uimm || w_needs_simm) begin
                            r_state <= S_FETCH_IMM;
                        end else begin
                            r_imm         <= '0;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_EMIT;
                        end
                    end
                end

                S_FETCH_IMM: begin
                    if (!r_mem_read_en) begin
                        r_mem_read_en <= 1'b1;
                    end else if (mem_ready) begin
                        r_mem_read_en <= 1'b0;
                        r_pc          <= w_pc_inc;
                        r_len         <= r_len + 3'd1;
                        if (!mem_data_out[7]) begin
                            r_imm         <= w_imm_final;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_EMIT;
                        end else if (w_leb_last) begin
                            // Continuation bit on the last permitted byte: malformed.
                            r_trap  <= 1'b1;
                            r_state <= S_TRAP;
                        end else begin
                            r_acc     <= w_acc_next;
                            r_leb_idx <= r_leb_idx + IDX_W'(1);
                        end
                    end
                end

                S_EMIT: begin
                    // Hold every field until execute takes the instruction.
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH_OP;
                    end
                end

                S_TRAP: begin
                    r_trap        <= 1'b1;
                    r_mem_read_en <= 1'b0;
                    r_instr_valid <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = r_pc;
    assign mem_read_en  = r_mem_read_en;
    assign instr_valid  = r_instr_valid;
    assign instr_opcode = r_opcode;
    assign instr_imm    = r_imm;
    assign instr_pc     = r_instr_pc;
    assign instr_len    = r_len;
    assign trap         = r_trap;
    assign busy         = (r_state != S_IDLE) && (r_state != S_TRAP);

endmodule

// File: tb/tb_wasm_fetch_decode.sv
// Scoreboard bench for wasm_fetch_decode: stimulus pushes hand-computed
// expected instructions, a negedge monitor pops and compares on handshakes.
module tb_wasm_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_mapped;
    logic [31:0] first_instruction;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic [7:0]  mem_data_out;
    logic        mem_ready;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [31:0] instr_imm;
    logic [31:0] instr_pc;
    logic [2:0]  instr_len;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        busy;

    wasm_fetch_decode #(.ADDR_W(32), .MAX_LEB_BYTES(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rom_mapped        (rom_mapped),
        .first_instruction (first_instruction),
        .mem_addr          (mem_addr),
        .mem_read_en       (mem_read_en),
        .mem_data_out      (mem_data_out),
        .mem_ready         (mem_ready),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr_opcode      (instr_opcode),
        .instr_imm         (instr_imm),
        .instr_pc          (instr_pc),
        .instr_len         (instr_len),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .trap              (trap),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  len;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem [256];
    int          n_total = 0;
    int          n_pass  = 0;
    bit          mem_auto;
    int          lat;
    logic        man_ready;
    logic [7:0]  man_data;
    int          load_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Load one encoded instruction at load_addr and, if emitted, queue its expectation.
    task automatic instr(input logic [47:0] bytes, input int n, input bit push,
                         input logic [7:0] op, input logic [31:0] imm, input logic [2:0] len);
        exp_t e;
        for (int i = 0; i < n; i++)
            mem[8'(load_addr + i)] = bytes[8*(n-1-i) +: 8];
        if (push) begin
            e.op = op; e.imm = imm; e.pc = 32'(load_addr); e.len = len;
            sb_q.push_back(e);
        end
        load_addr += n;
    endtask

    // Memory responder: auto mode answers reads after lat cycles, manual mode replays man_*.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_data_out = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (!mem_auto) begin
                mem_ready    = man_ready;
                mem_data_out = man_data;
            end else if (mem_read_en) begin
                if (cnt >= lat) begin
                    mem_ready    = 1'b1;
                    mem_data_out = mem[mem_addr[7:0]];
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: every handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_instr: got op %h pc %h, expected none", instr_opcode, instr_pc);
                end else begin
                    e = sb_q.pop_front();
                    $display("instr pc=%h op=%h imm=%h len=%0d", instr_pc, instr_opcode, instr_imm, instr_len);
                    chk("sb_opcode", 32'(instr_opcode), 32'(e.op));
                    chk("sb_imm",    instr_imm,         e.imm);
                    chk("sb_pc",     instr_pc,          e.pc);
                    chk("sb_len",    32'(instr_len),    32'(e.len));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rom_mapped = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        man_ready = 1'b0; man_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start(input logic [31:0] pc);
        @(negedge clk);
        #1;
        first_instruction = pc;
        rom_mapped = 1'b1;
        @(negedge clk);
        chk("start_read_en", 32'(mem_read_en), 32'd1);
        chk("start_addr",    mem_addr,          pc);
        chk("start_busy",    32'(busy),         32'd1);
        #1 rom_mapped = 1'b0;
    endtask

    // Wait for instr_valid, hold ready low for stall cycles checking stability, then accept.
    task automatic accept(input int stall);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!instr_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!instr_valid) begin
            n_total++;
            $display("FAIL accept_timeout: got no instr_valid, expected one within 300 cycles");
            return;
        end
        if (sb_q.size() > 0) e = sb_q[0];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid),  32'd1);
            chk("stall_op",    32'(instr_opcode), 32'(e.op));
            chk("stall_imm",   instr_imm,         e.imm);
            chk("stall_pc",    instr_pc,          e.pc);
            chk("stall_len",   32'(instr_len),    32'(e.len));
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    // Manually serve one byte read, checking its address.
    task automatic man_byte(input logic [31:0] addr, input logic [7:0] data, input bit redir);
        int t;
        t = 0;
        @(negedge clk);
        while (!mem_read_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("man_addr", mem_addr, addr);
        #1;
        man_ready = 1'b1;
        man_data  = data;
        if (redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h80;
        end
        @(negedge clk);
        #1;
        man_ready      = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_trap(input string name);
        int t;
        t = 0;
        while (!trap && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(trap), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_auto = 1'b1; lat = 1;
        first_instruction = 32'h0;

        // ---- Reset state and sequential decode ----
        do_reset();
        chk("rst_read_en", 32'(mem_read_en),  32'd0);
        chk("rst_valid",   32'(instr_valid),  32'd0);
        chk("rst_trap",    32'(trap),         32'd0);
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_addr",    mem_addr,          32'd0);
        chk("rst_opcode",  32'(instr_opcode), 32'd0);
        chk("rst_imm",     instr_imm,         32'd0);
        chk("rst_len",     32'(instr_len),    32'd0);

        load_addr = 32'h30;
        instr(48'h417F,         2, 1, 8'h41, 32'hFFFF_FFFF, 3'd2);
        instr(48'h20E58E26,     4, 1, 8'h20, 32'h0009_8765, 3'd4);
        instr(48'h41C0BB78,     4, 1, 8'h41, 32'hFFFE_1DC0, 3'd4);
        instr(48'h108001,       3, 1, 8'h10, 32'h0000_0080, 3'd3);
        instr(48'h6A,           1, 1, 8'h6A, 32'h0,         3'd1);
        instr(48'h0B,           1, 1, 8'h0B, 32'h0,         3'd1);
        instr(48'h21FFFFFFFF0F, 6, 1, 8'h21, 32'hFFFF_FFFF, 3'd6);
        instr(48'h22808080807F, 6, 1, 8'h22, 32'hF000_0000, 3'd6);
        instr(48'h418080808078, 6, 1, 8'h41, 32'h8000_0000, 3'd6);
        instr(48'h4140,         2, 1, 8'h41, 32'hFFFF_FFC0, 3'd2);

        start(32'h30);
        accept(0);
        accept(5);
        for (int i = 0; i < 8; i++) accept(0);

        // ---- Redirect during an immediate fetch ----
        do_reset();
        mem_auto = 1'b0; lat = 0;
        load_addr = 32'h80;
        instr(48'h2005, 2, 1, 8'h20, 32'h5, 3'd2);
        instr(48'h6B,   1, 1, 8'h6B, 32'h0, 3'd1);
        start(32'h60);
        man_byte(32'h60, 8'h20, 1'b0);
        man_byte(32'h61, 8'h85, 1'b0);
        man_byte(32'h62, 8'h01, 1'b1);
        mem_auto = 1'b1;
        chk("redir_read_en", 32'(mem_read_en), 32'd0);
        chk("redir_addr",    mem_addr,         32'h80);
        chk("redir_valid",   32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("redir_fetch_en",   32'(mem_read_en), 32'd1);
        chk("redir_fetch_addr", mem_addr,         32'h80);
        accept(0);
        accept(0);

        // ---- LEB overflow trap ----
        do_reset();
        load_addr = 32'h90;
        instr(48'h418080808080, 6, 0, 8'h0, 32'h0, 3'd0);
        instr(48'h01,           1, 0, 8'h0, 32'h0, 3'd0);
        instr_ready = 1'b1;
        start(32'h90);
        wait_trap("leb_trap");
        chk("leb_trap_addr", mem_addr, 32'h96);
        for (int i = 0; i < 4; i++) begin
            #1;
            redirect_valid = (i == 1);
            redirect_pc    = 32'h40;
            @(negedge clk);
            chk("trap_read_en", 32'(mem_read_en), 32'd0);
            chk("trap_sticky",  32'(trap),        32'd1);
        end
        chk("trap_busy",  32'(busy),        32'd0);
        chk("trap_valid", 32'(instr_valid), 32'd0);
        do_reset();
        @(negedge clk);
        chk("trap_cleared", 32'(trap), 32'd0);

        // ---- Unsupported opcode ----
        do_reset();
        load_addr = 32'hA0;
`ifdef WASM_ILLEGAL_TRAP_EN
        instr(48'hFC, 1, 0, 8'h0, 32'h0, 3'd0);
        instr(48'h45, 1, 0, 8'h0, 32'h0, 3'd0);
        instr_ready = 1'b1;
        start(32'hA0);
        wait_trap("illegal_trap");
        chk("illegal_valid", 32'(instr_valid), 32'd0);
        chk("illegal_addr",  mem_addr,         32'hA1);
`else
        instr(48'hFC, 1, 1, 8'hFC, 32'h0, 3'd1);
        instr(48'h45, 1, 1, 8'h45, 32'h0, 3'd1);
        start(32'hA0);
        accept(0);
        accept(0);
        chk("illegal_no_trap", 32'(trap), 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wasm_fetch_decode.md
Name: wasm_fetch_decode

Overview:
- Downstream consumer of the WASM loader.
- Waits for `rom_mapped`, then starts at `first_instruction` and fetches code bytes one at a time from the code memory the loader filled at CODE_BASE (0x30).
- Decodes each WASM opcode and its LEB128 immediate, if any, and presents one decoded instruction per valid/ready handshake to the execute stage.
- Accepts PC redirects from execute (branches, calls).

Parameters:
- ADDR_W, 32, width of code addresses and PC.
- MAX_LEB_BYTES, 5, maximum encoded length of an immediate, in bytes (32-bit value).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- rom_mapped  input  1  loader done; level signal.
- first_instruction  input  ADDR_W  entry PC; valid while rom_mapped=1.
- mem_addr  output  ADDR_W  code byte address.
- mem_read_en  output  1  read request.
- mem_data_out  input  8  read data; valid while mem_ready=1.
- mem_ready  input  1  read complete.
- instr_valid  output  1  decoded instruction available.
- instr_ready  input  1  execute accepts the instruction.
- instr_opcode  output  8  opcode byte.
- instr_imm  output  32  decoded immediate; 0 if the opcode has none.
- instr_pc  output  ADDR_W  address of the opcode byte.
- instr_len  output  3  total encoded length, 1..6 bytes.
- redirect_valid  input  1  PC redirect request.
- redirect_pc  input  ADDR_W  redirect target.
- trap  output  1  sticky decode fault.
- busy  output  1  high in any state other than S_IDLE and S_TRAP.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=S_IDLE; pc=0.
  - mem_read_en=0, instr_valid=0, trap=0, busy=0.
  - instr_* registers cleared to 0.
  - Reset mid-read abandons the request; a later mem_ready is ignored because state is S_IDLE.
- States: S_IDLE, S_FETCH_OP, S_FETCH_IMM, S_EMIT, S_TRAP.
- S_IDLE:
  - When rom_mapped=1: pc<=first_instruction, go to S_FETCH_OP.
  - Earliest opcode read request is 1 cycle after rom_mapped is sampled high.
- Memory handshake:
  - Drive mem_addr=pc and mem_read_en=1 until mem_ready is sampled high.
  - Capture mem_data_out in that cycle and set pc<=pc+1.
  - Drive mem_read_en=0 for the following cycle; there is at least one idle cycle between byte reads.
- S_FETCH_OP:
  - Latch opcode, instr_pc=pc, and the length counter=1.
  - Unsigned LEB immediate for opcodes 0x0C, 0x0D, 0x10, 0x20, 0x21, 0x22, 0x23, 0x24 → S_FETCH_IMM.
  - Signed LEB immediate for opcode 0x41 → S_FETCH_IMM.
  - All other opcodes → S_EMIT with imm=0.
- S_FETCH_IMM, per byte b at index n (0-based):
  - acc |= (b & 0x7F) << 7n; length counter +1.
  - If b[7]=0: the immediate is complete.
    - Signed case with n<4 and b[6]=1: sign-extend acc from bit 7(n+1)-1.
    - Go to S_EMIT.
  - If b[7]=1 and n=MAX_LEB_BYTES-1: raise trap and go to S_TRAP.
  - At n=4, only bits b[3:0] contribute; upper payload bits are discarded and do not trap.
- S_EMIT:
  - instr_valid=1 with all instr_* fields stable.
  - On instr_valid & instr_ready: instr_valid<=0 next cycle, go to S_FETCH_OP.
  - Fetch is sequential through opcode 0x0B; fetch does not stop on it.
- Redirect (redirect_valid=1 in S_FETCH_OP, S_FETCH_IMM or S_EMIT):
  - Highest priority.
  - Next cycle: pc<=redirect_pc, instr_valid<=0, mem_read_en<=0, partial immediate discarded, go to S_FETCH_OP.
  - A mem_ready in the same cycle is discarded.
  - A handshake completing in the same cycle counts as accepted; the redirect still applies.
- Redirect in S_IDLE or S_TRAP is ignored.
- S_TRAP:
  - trap=1, mem_read_en=0, instr_valid=0.
  - Left only via reset.
- rom_mapped falling after start is ignored.
- pc arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.

Optional Feature:
- Macro: WASM_ILLEGAL_TRAP_EN.
- Defined: an opcode outside the supported set {0x00, 0x01, 0x0B, 0x0C, 0x0D, 0x0F, 0x10, 0x1A, 0x20–0x24, 0x41, 0x45, 0x46, 0x6A, 0x6B, 0x6C} sets trap and goes to S_TRAP.
  - This happens 1 cycle after the opcode byte is captured; no instr_valid is raised for it.
- Undefined: unsupported opcodes are emitted as len=1, imm=0; trap is only raised on LEB overflow.

Test Plan:
- Reset, then rom_mapped=1 with first_instruction=0x30 → first mem_read_en with mem_addr=0x30; busy=1.
- Bytes 41 7F at 0x30 → opcode=0x41, imm=0xFFFFFFFF, len=2, pc=0x30; the next fetch is at 0x32.
- Bytes 20 E5 8E 26 → imm=624485 (0x98765), len=4; with instr_ready held low for 5 cycles, instr_valid and all fields stay stable.
- redirect_valid=1 with redirect_pc=0x80 during an immediate fetch → partial immediate dropped; the next mem_addr is 0x80; the stale mem_ready is ignored.
- Bytes 41 80 80 80 80 80 → trap=1 after the 5th immediate byte; no instr_valid; mem_read_en stays 0 until rst_n=0.
- Byte FC: with WASM_ILLEGAL_TRAP_EN → trap=1 and no instr_valid; without it → opcode=0xFC, imm=0, len=1 emitted.
